// File: rtl/creek_instr_fetch.sv
// creek_instr_fetch: instruction fetch stage for the Creek core.
//
// Walks a program counter through the instruction memory's read port. The
// memory has one cycle of registered read latency, and fetched words are
// buffered in a small queue that the decoder drains through a valid/ready
// handshake.
//
// Ports:
//   clk, reset       - single clock; asynchronous active-high reset
//   local_init_done  - memory calibration done; resume is ignored while low
//   pause_n          - low blocks new reads (in-flight read still lands)
//   resume           - pulse: (re)start the program at address 0
//   redirect_valid   - branch redirect to redirect_addr; flushes the queue
//   instr_address    - memory read address (the PC register)
//   instr_data       - memory read data, one cycle after the address
//   out_valid/out_ready/out_instr/out_pc - decoder handshake and head entry
//   fetch_done       - end of memory reached and everything drained
module creek_instr_fetch #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  local_init_done,
    input  logic                  pause_n,
    input  logic                  resume,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_addr,
    output logic [ADDR_WIDTH-1:0] instr_address,
    input  logic [DATA_WIDTH-1:0] instr_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_instr,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic                  fetch_done
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [1:0] {StIdle, StFetch, StDone} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] pending_pc_q, pending_pc_d;
    logic                  pending_q, pending_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]       count_q, count_d;
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_d [DEPTH];
    logic [ADDR_WIDTH-1:0] pcs_q [DEPTH];
    logic [ADDR_WIDTH-1:0] pcs_d [DEPTH];

    logic accept_resume, do_redirect, flush, credit_ok, issue, push, pop;

    always_comb begin
        accept_resume = resume && local_init_done;
        // Resume wins over a simultaneous redirect; redirects are ignored in IDLE.
        do_redirect   = redirect_valid && (state_q != StIdle) && !accept_resume;
        flush         = accept_resume || do_redirect;
        // Reserve a slot for the in-flight read so a capture never finds the queue full.
        credit_ok     = (count_q + CntW'(pending_q)) < CntW'(DEPTH);
        issue         = (state_q == StFetch) && pause_n && !flush && credit_ok;
        push          = pending_q && !flush;
        pop           = out_valid && out_ready;
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pending_d    = pending_q;
        pending_pc_d = pending_pc_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        data_d       = data_q;
        pcs_d        = pcs_q;

        if (flush) begin
            state_d   = StFetch;
            pc_d      = accept_resume ? '0 : redirect_addr;
            pending_d = 1'b0;
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
            count_d   = '0;
        end else begin
            pending_d = issue;
            if (issue) begin
                pc_d         = pc_q + ADDR_WIDTH'(1);
                pending_pc_d = pc_q;
                // Issuing the last address ends the program; PC wraps to 0.
                if (&pc_q) begin
                    state_d = StDone;
                end
            end
            if (push) begin
                data_d[wr_ptr_q] = instr_data;
                pcs_d[wr_ptr_q]  = pending_pc_q;
                wr_ptr_d         = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            pc_q         <= '0;
            pending_q    <= 1'b0;
            pending_pc_q <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_q[i] <= '0;
                pcs_q[i]  <= '0;
            end
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pending_q    <= pending_d;
            pending_pc_q <= pending_pc_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            data_q       <= data_d;
            pcs_q        <= pcs_d;
        end
    end

    always_comb begin
        instr_address = pc_q;
        out_valid     = (count_q != '0);
        out_instr     = data_q[rd_ptr_q];
        out_pc        = pcs_q[rd_ptr_q];
        fetch_done    = (state_q == StDone) && (count_q == '0) && !pending_q;
    end

endmodule

// File: tb/tb_creek_instr_fetch.sv
// Testbench for creek_instr_fetch: a 10-bit-address instance (a) for stream,
// backpressure, redirect, pause, init gating and reset, and a 4-bit-address
// instance (b) for wrap-around and fetch_done.
module tb_creek_instr_fetch;

    logic clk;
    logic reset;

    logic        init_a, pause_a, resume_a, redir_a, ready_a;
    logic [9:0]  raddr_a, addr_a, opc_a;
    logic [15:0] idata_a, oinstr_a;
    logic        oval_a, done_a;

    logic        init_b, pause_b, resume_b, redir_b, ready_b;
    logic [3:0]  raddr_b, addr_b, opc_b;
    logic [15:0] idata_b, oinstr_b;
    logic        oval_b, done_b;

    int checks = 0;
    int errors = 0;

    // Reference model state: next expected PC per instance, run flag, stats.
    int unsigned exp_a = 0, exp_b = 0;
    bit          run_a = 0, run_b = 0;
    bit          saw15_b = 0;
    int          t15_b = 0;
    int          cyc = 0;
    int          pops_a = 0;

    creek_instr_fetch #(.ADDR_WIDTH(10), .DATA_WIDTH(16), .DEPTH(4)) dut_a (
        .clk            (clk),
        .reset          (reset),
        .local_init_done(init_a),
        .pause_n        (pause_a),
        .resume         (resume_a),
        .redirect_valid (redir_a),
        .redirect_addr  (raddr_a),
        .instr_address  (addr_a),
        .instr_data     (idata_a),
        .out_valid      (oval_a),
        .out_ready      (ready_a),
        .out_instr      (oinstr_a),
        .out_pc         (opc_a),
        .fetch_done     (done_a)
    );

    creek_instr_fetch #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .DEPTH(4)) dut_b (
        .clk            (clk),
        .reset          (reset),
        .local_init_done(init_b),
        .pause_n        (pause_b),
        .resume         (resume_b),
        .redirect_valid (redir_b),
        .redirect_addr  (raddr_b),
        .instr_address  (addr_b),
        .instr_data     (idata_b),
        .out_valid      (oval_b),
        .out_ready      (ready_b),
        .out_instr      (oinstr_b),
        .out_pc         (opc_b),
        .fetch_done     (done_b)
    );

    // Memory models: registered read, word = 16'hA000 + address.
    always @(posedge clk) begin
        idata_a <= 16'hA000 + 16'(addr_a);
        idata_b <= 16'hA000 + 16'(addr_b);
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check this cycle's handshakes against the model, update the model for
    // any flush applied this cycle, then advance to 1 time unit after the edge.
    task automatic tick();
        if (oval_a) chk("a_data", 32'(oinstr_a), 32'(16'hA000 + 16'(opc_a)));
        if (oval_a && ready_a) begin
            chk("a_order", 32'(opc_a), exp_a);
            exp_a = (exp_a + 1) % 1024;
            pops_a++;
        end
        if (resume_a && init_a) begin
            run_a = 1;
            exp_a = 0;
        end else if (redir_a && run_a) begin
            exp_a = 32'(raddr_a);
        end
        if (oval_b) chk("b_data", 32'(oinstr_b), 32'(16'hA000 + 16'(opc_b)));
        if (oval_b && ready_b) begin
            chk("b_order", 32'(opc_b), exp_b);
            if (opc_b == 4'd15) begin
                saw15_b = 1;
                t15_b   = cyc;
            end
            exp_b = (exp_b + 1) % 16;
        end
        if (resume_b && init_b) begin
            run_b = 1;
            exp_b = 0;
        end else if (redir_b && run_b) begin
            exp_b = 32'(raddr_b);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        int n;
        int p0;
        logic [9:0] hold_addr;

        reset = 1'b1;
        init_a = 1'b1; pause_a = 1'b1; resume_a = 1'b0; redir_a = 1'b0; ready_a = 1'b1;
        raddr_a = '0;
        init_b = 1'b1; pause_b = 1'b1; resume_b = 1'b0; redir_b = 1'b0; ready_b = 1'b1;
        raddr_b = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset values
        chk("rst_addr", 32'(addr_a), 0);
        chk("rst_valid", 32'(oval_a), 0);
        chk("rst_instr", 32'(oinstr_a), 0);
        chk("rst_pc", 32'(opc_a), 0);
        chk("rst_done", 32'(done_a), 0);
        chk("rst_done_b", 32'(done_b), 0);
        reset = 1'b0;
        tick();

        // Init gating: resume ignored while local_init_done is low
        init_a = 1'b0;
        resume_a = 1'b1;
        tick();
        resume_a = 1'b0;
        init_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("gate_valid", 32'(oval_a), 0);
            chk("gate_addr", 32'(addr_a), 0);
            tick();
        end

        // Basic stream
        resume_a = 1'b1;
        tick();
        resume_a = 1'b0;
        chk("bs_v1", 32'(oval_a), 0);
        tick();
        chk("bs_v2", 32'(oval_a), 0);
        tick();
        chk("bs_v3", 32'(oval_a), 1);
        chk("bs_pc0", 32'(opc_a), 0);
        chk("bs_instr0", 32'(oinstr_a), 32'h0000_A000);
        chk("bs_addr", 32'(addr_a), 2);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("bs_steady", 32'(oval_a), 1);
        end

        // Backpressure from a fresh start
        ready_a = 1'b0;
        resume_a = 1'b1;
        tick();
        resume_a = 1'b0;
        repeat (10) tick();
        chk("bp_addr", 32'(addr_a), 4);
        chk("bp_head", 32'(opc_a), 0);
        ready_a = 1'b1;
        for (int i = 0; i < 12; i++) begin
            chk("bp_nogap", 32'(oval_a), 1);
            tick();
        end

        // Redirect while the queue holds PCs 5..7
        resume_a = 1'b1;
        tick();
        resume_a = 1'b0;
        repeat (7) tick();
        ready_a = 1'b0;
        tick();
        tick();
        chk("rd_head5", 32'(opc_a), 5);
        redir_a = 1'b1;
        raddr_a = 10'h200;
        tick();
        redir_a = 1'b0;
        ready_a = 1'b1;
        chk("rd_v1", 32'(oval_a), 0);
        chk("rd_addr", 32'(addr_a), 32'h200);
        tick();
        chk("rd_v2", 32'(oval_a), 0);
        tick();
        chk("rd_v3", 32'(oval_a), 1);
        chk("rd_pc", 32'(opc_a), 32'h200);
        chk("rd_instr", 32'(oinstr_a), 32'h0000_A200);
        repeat (4) tick();

        // Pause for 5 cycles during streaming
        pause_a = 1'b0;
        hold_addr = addr_a;
        tick();
        p0 = pops_a;
        for (int i = 0; i < 4; i++) begin
            chk("pz_addr", 32'(addr_a), 32'(hold_addr));
            tick();
        end
        chk("pz_addr_end", 32'(addr_a), 32'(hold_addr));
        pause_a = 1'b1;
        tick();
        chk("pz_captures", 32'(pops_a - p0 <= 1), 1);
        repeat (4) tick();
        chk("pz_continue", 32'(oval_a), 1);

        // Randomized traffic; the model tracks order and data
        for (int i = 0; i < 400; i++) begin
            ready_a = ($urandom_range(0, 3) != 0);
            pause_a = ($urandom_range(0, 4) != 0);
            redir_a = ($urandom_range(0, 39) == 0);
            raddr_a = 10'($urandom_range(0, 1023));
            tick();
        end
        redir_a = 1'b0;
        ready_a = 1'b1;
        pause_a = 1'b1;

        // Wrap and fetch_done on the 4-bit instance
        resume_b = 1'b1;
        tick();
        resume_b = 1'b0;
        n = 0;
        while (!done_b && n < 80) begin
            tick();
            n++;
        end
        chk("wr_done", 32'(done_b), 1);
        chk("wr_saw15", 32'(saw15_b), 1);
        chk("wr_done_lat", 32'(cyc - t15_b), 1);
        chk("wr_valid", 32'(oval_b), 0);
        chk("wr_addr", 32'(addr_b), 0);
        tick();
        chk("wr_done_hold", 32'(done_b), 1);
        redir_b = 1'b1;
        raddr_b = 4'd3;
        tick();
        redir_b = 1'b0;
        chk("wr_done_clr", 32'(done_b), 0);
        tick();
        tick();
        chk("wr_rd_valid", 32'(oval_b), 1);
        chk("wr_rd_pc", 32'(opc_b), 3);
        tick();

        // Reset mid-stream
        resume_a = 1'b1;
        tick();
        resume_a = 1'b0;
        repeat (5) tick();
        chk("mr_pre_valid", 32'(oval_a), 1);
        reset = 1'b1;
        #1;
        chk("mr_valid", 32'(oval_a), 0);
        chk("mr_instr", 32'(oinstr_a), 0);
        chk("mr_pc", 32'(opc_a), 0);
        chk("mr_addr", 32'(addr_a), 0);
        chk("mr_done", 32'(done_a), 0);
        chk("mr_valid_b", 32'(oval_b), 0);
        run_a = 0;
        run_b = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mr_idle_valid", 32'(oval_a), 0);
            chk("mr_idle_addr", 32'(addr_a), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
